speed_decoder: RTL
==================

Name: speed_decoder

Overview:
- Inverse of the game's tick generator. It watches a single-cycle enable/tick strobe and measures the cycle spacing between strobes.
- It decodes that spacing back into the 2-bit Speed code that produced it: 00 = every cycle, 01 = F, 10 = 2F, 11 = 4F cycles.
- Used to check and monitor lane/obstacle tick rates in the Crossy Road datapath.
- Adds debounced lock, error and stall reporting.

Parameters:
- CLOCK_FREQUENCY, 50000000, F: base tick period in cycles for Speed 01.
- TOL, 1000, ± tolerance in cycles for the 01/10/11 windows. Must satisfy TOL < F/2; elaboration fails otherwise.
- LOCK_COUNT, 2, consecutive identical classifications required to lock or relock (range 1..7).
- CW, 30, interval counter width. Must hold 4F+TOL+1.

Ports:
- ClockIn  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- PulseIn  in  1  tick strobe to decode. Consecutive high cycles count as separate pulses.
- SpeedOut  out  2  decoded Speed code; valid when Valid=1.
- Valid  out  1  decoder is locked; SpeedOut is meaningful.
- Changed  out  1  one-cycle pulse when (Valid, SpeedOut) changes because of a lock or relock.
- Error  out  1  one-cycle pulse on an unclassifiable interval.
- Stalled  out  1  no pulse within 4F+TOL cycles; held until the next pulse.

Behaviour:
- Reset (sampled on a ClockIn edge): state IDLE, IntervalCount=0, MatchCnt=0, Candidate=00. SpeedOut=00, Valid=0, Changed=0, Error=0, Stalled=0. Reset mid-operation aborts any measurement or lock identically.
- IntervalCount, every cycle:
  - PulseIn=1: loads 0.
  - Otherwise: increments, saturating at 2^CW-1.
- Measured interval on a pulse cycle: M = IntervalCount+1. Back-to-back pulses give M=1; pulses at cycles t and t+F give M=F.
- Classification (combinational, CW-bit unsigned, no wrap):
  - M==1 → 00.
  - F-TOL <= M <= F+TOL → 01.
  - 2F-TOL <= M <= 2F+TOL → 10.
  - 4F-TOL <= M <= 4F+TOL → 11.
  - Anything else → invalid.
- All outputs are registered. The response to a pulse in cycle t appears in cycle t+1 (latency 1). Changed and Error are high for exactly one cycle.
- States:
  - IDLE: no timing reference. Outputs held except Valid=0.
    - PulseIn → MEASURE; clear Stalled; MatchCnt=0; no classification.
  - MEASURE (Valid=0), on a pulse:
    - Valid code C: if MatchCnt>0 and C==Candidate, MatchCnt++; otherwise Candidate=C and MatchCnt=1.
    - When MatchCnt reaches LOCK_COUNT: SpeedOut=C, Valid=1, Changed=1, MatchCnt=0 → LOCKED.
    - Invalid: Error=1, MatchCnt=0, stay in MEASURE.
  - LOCKED (Valid=1), on a pulse:
    - C==SpeedOut: MatchCnt=0, no output change.
    - C!=SpeedOut: same candidate counting as MEASURE. SpeedOut holds the old value until LOCK_COUNT consecutive matches, then SpeedOut=C and Changed=1.
    - Invalid: Error=1, Valid=0, MatchCnt=0 → MEASURE.
- Timeout: in MEASURE or LOCKED, with PulseIn=0 and IntervalCount==4F+TOL → Valid=0, Stalled=1, MatchCnt=0 → IDLE.
  - SpeedOut keeps its last value.
  - A pulse in the same cycle wins: it is classified normally, with M=4F+TOL+1, which is invalid.
- With LOCK_COUNT=1, every valid pulse locks or relocks immediately.
- Changed and Error are never asserted in the same cycle.

Test Plan (F=20, TOL=2, LOCK_COUNT=2):
1. Reset, then PulseIn held high from cycle 0:
   - pulses 1 and 2 give M=1,1 → cycle 3: Valid=1, SpeedOut=00, Changed=1 for one cycle;
   - further cycles give no Changed.
2. Pulses every 40 cycles from reset → two M=40 intervals → Valid=1, SpeedOut=10 the cycle after the third pulse.
3. Locked at 10, then pulses every 21 cycles → SpeedOut stays 10 after the first M=21, switches to 01 with Changed=1 after the second. Valid stays 1 throughout.
4. Locked at 01, then a single M=30 interval:
   - Error=1 for one cycle, Valid=0;
   - following M=80 and M=80 → SpeedOut=11, Valid=1.
5. Locked, then PulseIn held low:
   - when IntervalCount reaches 82: Valid=0, Stalled=1, SpeedOut unchanged;
   - next pulse clears Stalled, with no classification;
   - two more M=20 intervals relock to 01.
6. Boundary and reset:
   - M=18, M=22 accepted as 01; M=17 → Error; M=23 → Error;
   - Reset asserted while LOCKED → all outputs 0 in the next cycle and state IDLE.

Source files
------------

// File: rtl/speed_decoder.sv
// Recovers the 2-bit Speed code from the spacing of a tick strobe.
// Also reports debounced lock, one-cycle change/error pulses and a stall flag.
module speed_decoder #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int TOL             = 1000,
  parameter int LOCK_COUNT      = 2,
  parameter int CW              = 30
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       PulseIn,
  output logic [1:0] SpeedOut,
  output logic       Valid,
  output logic       Changed,
  output logic       Error,
  output logic       Stalled
);

  localparam int F = CLOCK_FREQUENCY;

  if (TOL < 0 || TOL >= F / 2) begin : g_badTol
    $error("speed_decoder: TOL must satisfy 0 <= TOL < CLOCK_FREQUENCY/2");
  end
  if (LOCK_COUNT < 1 || LOCK_COUNT > 7) begin : g_badLock
    $error("speed_decoder: LOCK_COUNT must be in 1..7");
  end
  if (longint'(4 * F + TOL + 1) > ((longint'(1) << CW) - 1)) begin : g_badCw
    $error("speed_decoder: CW too narrow for 4F+TOL+1");
  end

  localparam logic [CW:0]   M_ONE      = (CW+1)'(1);
  localparam logic [CW:0]   F1_LO      = (CW+1)'(F - TOL);
  localparam logic [CW:0]   F1_HI      = (CW+1)'(F + TOL);
  localparam logic [CW:0]   F2_LO      = (CW+1)'(2 * F - TOL);
  localparam logic [CW:0]   F2_HI      = (CW+1)'(2 * F + TOL);
  localparam logic [CW:0]   F4_LO      = (CW+1)'(4 * F - TOL);
  localparam logic [CW:0]   F4_HI      = (CW+1)'(4 * F + TOL);
  localparam logic [CW-1:0] TIMEOUT_AT = CW'(4 * F + TOL);
  localparam logic [2:0]    LOCK3      = 3'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  state_t          r_State;
  logic [CW-1:0]   r_IntervalCount;
  logic [2:0]      r_MatchCnt;
  logic [1:0]      r_Candidate;
  logic [1:0]      r_SpeedOut;
  logic            r_Valid;
  logic            r_Changed;
  logic            r_Error;
  logic            r_Stalled;

  logic [CW:0]     w_measured;
  logic            w_codeValid;
  logic [1:0]      w_code;
  logic [2:0]      w_nextMatch;
  logic            w_reachLock;
  logic            w_timeout;

  // One extra bit so the saturated count plus one cannot wrap into a valid window.
  assign w_measured = {1'b0, r_IntervalCount} + M_ONE;

  always_comb begin
    w_codeValid = 1'b1;
    w_code      = 2'b00;
    if (w_measured == M_ONE) begin
      w_code = 2'b00;
    end else if (w_measured >= F1_LO && w_measured <= F1_HI) begin
      w_code = 2'b01;
    end else if (w_measured >= F2_LO && w_measured <= F2_HI) begin
      w_code = 2'b10;
    end else if (w_measured >= F4_LO && w_measured <= F4_HI) begin
      w_code = 2'b11;
    end else begin
      w_codeValid = 1'b0;
    end
  end

  assign w_nextMatch = (r_MatchCnt != 3'd0 && w_code == r_Candidate) ? r_MatchCnt + 3'd1 : 3'd1;
  assign w_reachLock = (w_nextMatch == LOCK3);
  assign w_timeout   = !PulseIn && (r_IntervalCount == TIMEOUT_AT);

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      r_IntervalCount <= '0;
    end else if (PulseIn) begin
      r_IntervalCount <= '0;
    end else if (r_IntervalCount != '1) begin
      r_IntervalCount <= r_IntervalCount + 1'b1;
    end
  end

  // A pulse always takes priority over the timeout in the same cycle.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      r_State     <= IDLE;
      r_MatchCnt  <= 3'd0;
      r_Candidate <= 2'b00;
      r_SpeedOut  <= 2'b00;
      r_Valid     <= 1'b0;
      r_Changed   <= 1'b0;
      r_Error     <= 1'b0;
      r_Stalled   <= 1'b0;
    end else begin
      r_Changed <= 1'b0;
      r_Error   <= 1'b0;
      case (r_State)
        IDLE: begin
          r_Valid <= 1'b0;
          if (PulseIn) begin
            r_State    <= MEASURE;
            r_Stalled  <= 1'b0;
            r_MatchCnt <= 3'd0;
          end
        end
        MEASURE, LOCKED: begin
          if (PulseIn) begin
            if (!w_codeValid) begin
              r_Error    <= 1'b1;
              r_Valid    <= 1'b0;
              r_MatchCnt <= 3'd0;
              r_State    <= MEASURE;
            end else if (r_State == LOCKED && w_code == r_SpeedOut) begin
              r_MatchCnt <= 3'd0;
            end else begin
              r_Candidate <= w_code;
              if (w_reachLock) begin
                r_SpeedOut <= w_code;
                r_Valid    <= 1'b1;
                r_Changed  <= 1'b1;
                r_MatchCnt <= 3'd0;
                r_State    <= LOCKED;
              end else begin
                r_MatchCnt <= w_nextMatch;
              end
            end
          end else if (w_timeout) begin
            r_Valid    <= 1'b0;
            r_Stalled  <= 1'b1;
            r_MatchCnt <= 3'd0;
            r_State    <= IDLE;
          end
        end
        default: r_State <= IDLE;
      endcase
    end
  end

  assign SpeedOut = r_SpeedOut;
  assign Valid    = r_Valid;
  assign Changed  = r_Changed;
  assign Error    = r_Error;
  assign Stalled  = r_Stalled;

endmodule
